jtag_er1_regbank: RTL
=====================

Name: jtag_er1_regbank

Overview:
- ER1 user data-register stage inside the IP core, directly downstream of the JTAGG primitive.
- Consumes the JTAGG ER1 control strobes and TDI. Deserialises 32-bit LSB-first frames, decodes them into commands on a small user register bank, and drives JTDO1 back to the primitive.
- Register 0 drives the LED matrix outputs.
- All logic is clocked by JTCK, so no clock-domain crossing exists inside this block.

Parameters:
- NREGS, 4: number of user registers; valid addresses are 0..NREGS-1, with NREGS ≤ 16.
- DATA_W, 24: user register width; fixed equal to the frame data field.
- CAPTURE_TAG, 3'b101: constant placed in the top bits of every captured word.

Ports:
- JTCK  input  1  JTAG clock from JTAGG; all state updates on rising edge.
- JRSTN  input  1  asynchronous active-low reset from JTAGG.
- JTDI  input  1  serial data in.
- JSHIFT  input  1  TAP in Shift-DR.
- JUPDATE  input  1  TAP in Update-DR; not qualified by instruction.
- JCE1  input  1  ER1 selected and TAP in Capture-DR or Shift-DR.
- JTDO1  output  1  serial data out; combinational equal to sreg[0].
- USER_REGS  output  NREGS*DATA_W  flattened register bank; reg i occupies bits [i*DATA_W +: DATA_W].
- CMD_STROBE  output  1  one-JTCK pulse when a valid frame executes.
- LEDS  output  9  equal to reg0[8:0].
- LEDS_columns  output  4  equal to reg0[12:9].

Behaviour:
- Reset (JRSTN low, asynchronous):
  - sreg, all user regs, rd_addr, bitcnt, err, er1_sel and CMD_STROBE are cleared to 0.
  - Consequently JTDO1, LEDS and LEDS_columns are 0.
- Frame format (32 bits, shifted LSB first): [31:28] opcode, [27:24] addr, [23:0] data.
- Capture (rising JTCK with JCE1=1 and JSHIFT=0):
  - sreg loads {CAPTURE_TAG, err, rd_addr, rd_data}.
  - rd_data is reg[rd_addr] when rd_addr < NREGS, else 0.
  - bitcnt is set to 0 and er1_sel is set to 1.
- Shift (JCE1=1 and JSHIFT=1):
  - sreg <= {JTDI, sreg[31:1]}.
  - bitcnt increments and saturates at 63.
  - JTDO1 presents the next bit immediately; the primitive handles TDO edge timing.
- Update (JUPDATE=1 and er1_sel=1):
  - er1_sel is cleared.
  - If bitcnt ≠ 32, the frame is discarded: err is set to 1, no register change, CMD_STROBE stays 0.
  - If bitcnt = 32, the opcode executes on this edge, CMD_STROBE=1 for exactly one cycle, and err is cleared, except as noted below.
  - Opcode 0x1 WRITE: if addr < NREGS, reg[addr] <= data. Otherwise no write, err=1, and CMD_STROBE is still pulsed.
  - Opcode 0x2 READ: rd_addr <= addr. The value returns in the next capture; an out-of-range addr returns data 0.
  - Opcode 0x3 CLEAR: all regs set to 0; rd_addr unchanged.
  - Any other opcode: NOP, with no error.
- JUPDATE while er1_sel=0 (an ER2 or IR update) is ignored entirely.
- JCE1 with JSHIFT=0 in the same cycle as JUPDATE cannot occur per the TAP; if it does, capture has priority and the update is dropped.
- Register writes are visible on USER_REGS, LEDS and LEDS_columns on the cycle after the update edge.
- Latency: last shift bit to register visible is two JTCK edges (Exit1 and Update states).
- Asynchronous reset mid-frame aborts the frame. The next frame requires a fresh capture, because er1_sel is 0 after reset.
- Implementation:
  - The FSM is implicit in er1_sel plus bitcnt. Implement these as explicit registers; no latches.
  - JTDO1 is the only combinational output.

Test Plan:
- Reset, then check outputs: JRSTN low for 3 JTCK → LEDS=0, LEDS_columns=0, JTDO1=0, USER_REGS=0, CMD_STROBE=0.
- WRITE to reg 0: capture, shift 32'h1000_1FFF, update → CMD_STROBE one cycle, reg0=24'h001FFF, LEDS=9'h1FF, LEDS_columns=4'hF, err=0.
- READ round-trip:
  - WRITE 32'h1200_ABCD, then frame 32'h2200_0000 → CMD_STROBE pulse.
  - Next capture shifts out, LSB first, 32'hA200_ABCD (tag 101, err 0, addr 2, data 00ABCD).
- Short frame: capture, shift 31 bits of 32'h1000_0001, update → no write, reg0 unchanged, CMD_STROBE=0. Next capture word bit 28 = 1.
- Out-of-range address and recovery:
  - WRITE to addr 5 with NREGS=4 → no change, err=1.
  - Then a valid NOP frame 32'h0000_0000 → err=0 on the following capture.
- ER2 isolation, CLEAR, and reset mid-frame:
  - JUPDATE pulse without a preceding JCE1 → no effect.
  - CLEAR frame 32'h3000_0000 → all regs 0.
  - JRSTN low after 10 shift bits → all state 0; the subsequent update is ignored.

Source files
------------

// File: rtl/jtag_er1_regbank.sv
// ER1 user data register: deserialises 32-bit LSB-first JTAG frames into commands on a small register bank.
// Latency: last shift bit -> register visible after two JTCK edges (Exit1, Update); JTDO1 is combinational from sreg[0].
// Backpressure: none; the TAP controller paces every transfer, and frames that are not exactly 32 bits are dropped with err set.
module jtag_er1_regbank #(
    parameter int          NREGS       = 4,
    parameter int          DATA_W      = 24,
    parameter logic [2:0]  CAPTURE_TAG = 3'b101
) (
    input  logic                      JTCK,
    input  logic                      JRSTN,
    input  logic                      JTDI,
    input  logic                      JSHIFT,
    input  logic                      JUPDATE,
    input  logic                      JCE1,
    output logic                      JTDO1,
    output logic [NREGS*DATA_W-1:0]   USER_REGS,
    output logic                      CMD_STROBE,
    output logic [8:0]                LEDS,
    output logic [3:0]                LEDS_columns
);

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'h3;
    localparam logic [4:0] NREGS_L  = 5'(NREGS);

    logic [31:0]        r_sreg;
    logic [5:0]         r_bitcnt;
    logic               r_er1_sel;
    logic               r_err;
    logic [3:0]         r_rd_addr;
    logic               r_strobe;
    logic [DATA_W-1:0]  r_regs [NREGS];

    logic               w_capture;
    logic               w_shift;
    logic               w_update;
    logic               w_frame_ok;
    logic               w_exec;
    logic [3:0]         w_opcode;
    logic [3:0]         w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_addr_ok;
    logic [DATA_W-1:0]  w_rd_data;

    // Capture wins over everything; shift and update are mutually exclusive in a real TAP.
    assign w_capture  = JCE1 & ~JSHIFT;
    assign w_shift    = JCE1 & JSHIFT;
    assign w_update   = JUPDATE & r_er1_sel & ~JCE1;
    assign w_frame_ok = (r_bitcnt == 6'd32);
    assign w_exec     = w_update & w_frame_ok;
    assign w_opcode   = r_sreg[31:28];
    assign w_addr     = r_sreg[27:24];
    assign w_data     = r_sreg[DATA_W-1:0];
    assign w_addr_ok  = ({1'b0, w_addr} < NREGS_L);

    // Read-back mux; addresses beyond the bank read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (r_rd_addr == 4'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Shift register, frame bookkeeping and error/read-address state.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_sreg    <= '0;
            r_bitcnt  <= '0;
            r_er1_sel <= 1'b0;
            r_err     <= 1'b0;
            r_rd_addr <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_capture) begin
                r_sreg    <= {CAPTURE_TAG, r_err, r_rd_addr, w_rd_data};
                r_bitcnt  <= '0;
                r_er1_sel <= 1'b1;
            end else if (w_shift) begin
                r_sreg <= {JTDI, r_sreg[31:1]};
                if (r_bitcnt != 6'd63) begin
                    r_bitcnt <= r_bitcnt + 6'd1;
                end
            end else if (w_update) begin
                r_er1_sel <= 1'b0;
                if (!w_frame_ok) begin
                    r_err <= 1'b1;
                end else begin
                    r_strobe <= 1'b1;
                    r_err    <= (w_opcode == OP_WRITE) && !w_addr_ok;
                    if (w_opcode == OP_READ) begin
                        r_rd_addr <= w_addr;
                    end
                end
            end
        end
    end

    // User register bank: single-register write or whole-bank clear on a valid frame.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_exec) begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_opcode == OP_CLEAR) begin
                    r_regs[i] <= '0;
                end else if ((w_opcode == OP_WRITE) && (w_addr == 4'(i))) begin
                    r_regs[i] <= w_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign USER_REGS[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign JTDO1        = r_sreg[0];
    assign CMD_STROBE   = r_strobe;
    assign LEDS         = r_regs[0][8:0];
    assign LEDS_columns = r_regs[0][12:9];

endmodule
